multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle sequencer for the LEGv8 decode/execute datapath. It replaces single-cycle control decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It asserts per-state datapath enables and waits on a data-memory ready handshake. It sits beside the register file, ALU and data memory and drives the same control-signal set used by the decode stage, plus PC/IR enables.

## Interface
Parameters:
- none (opcode constants and state encoding come from the shared package)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- opcode  input  11  instruction bits [31:21] from the IR; valid from DECODE onward
- zero  input  1  ALU zero flag, sampled in BRANCH
- mem_ready  input  1  data memory completes the current read/write this cycle
- ir_write  output  1  load IR from instruction memory
- pc_write  output  1  update PC this cycle
- pc_src  output  1  0 = PC+4, 1 = branch target; meaningful only with pc_write
- reg2_loc  output  1  0 = Rm[20:16], 1 = Rt[4:0] as read register 2
- alu_src  output  1  0 = register, 1 = sign-extended immediate
- alu_op  output  2  ALUOp_LDST 00, ALUOp_CBZ 01, ALUOp_RTYPE 10
- mem_read  output  1  data memory read strobe
- mem_write  output  1  data memory write strobe
- mem_to_reg  output  1  writeback source is memory
- reg_write  output  1  register file write enable
- instr_done  output  1  one-cycle pulse at instruction retirement
- illegal  output  1  sticky undefined-opcode flag

## Operation
- Decoded classes:
  - ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 → RTYPE
  - LDUR 0x7C2 → LOAD
  - STUR 0x7C0 → STORE
  - CBZ 0x5A0–0x5A7 → CBZ
  - B 0x0A0–0x0BF → B
  - anything else → ILL
- States and transitions:
  - FETCH → DECODE.
  - DECODE → EXEC_R (RTYPE), ADDR (LOAD/STORE), BRANCH (CBZ), JUMP (B), ILLEGAL (ILL). The class is latched into a register on this edge.
  - EXEC_R → WB_R.
  - ADDR → MEM_RD (LOAD) or MEM_WR (STORE).
  - MEM_RD → WB_LD when mem_ready; otherwise stays.
  - MEM_WR → FETCH when mem_ready; otherwise stays.
  - WB_R, WB_LD, BRANCH, JUMP → FETCH.
  - ILLEGAL → ILLEGAL until reset.
- Outputs are decoded combinationally from the state plus the latched class. Any output not listed for a state is 0.
  - FETCH: ir_write=1.
  - DECODE: reg2_loc = 1 if opcode decodes to STORE or CBZ (uses live opcode).
  - EXEC_R: alu_op=RTYPE.
  - ADDR: alu_src=1, alu_op=LDST; reg2_loc=1 if STORE.
  - MEM_RD: alu_src=1, mem_read=1.
  - MEM_WR: alu_src=1, reg2_loc=1, mem_write=1; on the mem_ready cycle also pc_write=1, pc_src=0, instr_done=1.
  - WB_R: alu_op=RTYPE, reg_write=1, pc_write=1, pc_src=0, instr_done=1.
  - WB_LD: mem_to_reg=1, reg_write=1, pc_write=1, pc_src=0, instr_done=1.
  - BRANCH: reg2_loc=1, alu_op=CBZ, pc_write=1, pc_src=zero, instr_done=1.
  - JUMP: pc_write=1, pc_src=1, instr_done=1.
  - ILLEGAL: illegal=1; no other output asserts.
- mem_ready is ignored outside MEM_RD and MEM_WR.
- mem_read and mem_write are never asserted together.

## Timing
- Reset:
  - An edge with rst_n=0 forces state to FETCH and clears the class register.
  - While rst_n=0, every output is forced to 0, including illegal.
  - The first cycle after release is FETCH with ir_write=1.
- Latency from FETCH to the instr_done cycle inclusive:
  - RTYPE 4 cycles
  - LOAD 5 + n
  - STORE 4 + n
  - CBZ 3
  - B 3
  - n = number of cycles mem_ready is low while waiting.
- mem_ready already high on the first MEM_RD/MEM_WR cycle means zero wait.
- Reset mid-MEM_RD or mid-MEM_WR: strobes drop in the reset cycle; no reg_write, pc_write or instr_done is issued for the aborted instruction.
- Opcode changes after DECODE do not affect sequencing.

## Structure
- Shared package `control_pkg`:
  - state enum `ctrl_state_t`
  - class enum `instr_class_t`
  - the six opcode constants
  - ALUOp encodings, consistent with the existing `ALUOp_*` macros
- Sub-module `opcode_classify`: combinational opcode → `instr_class_t`. It is instantiated once, used in DECODE and for DECODE-state reg2_loc.

## Test plan
- Release reset with opcode=0x458 → FETCH(ir_write), DECODE, EXEC_R(alu_op=10), WB_R(reg_write, pc_write, pc_src=0, instr_done) → FETCH; 4 cycles.
- opcode=0x7C2, mem_ready low 2 cycles → mem_read high 3 cycles, then WB_LD with mem_to_reg=1, reg_write=1; 7 cycles total.
- opcode=0x7C0, mem_ready high immediately → ADDR reg2_loc=1, alu_src=1; one MEM_WR cycle with mem_write, pc_write, instr_done; reg_write never 1.
- opcode=0x5A3 with zero=1, then again with zero=0 → BRANCH pc_write=1 with pc_src=1, then pc_src=0; both 3 cycles. opcode=0x0AF → JUMP pc_src=1.
- opcode=0x765 → ILLEGAL, illegal=1 held 10+ cycles with no writes; rst_n=0 for one edge → illegal=0, FETCH.
- Assert rst_n=0 during a MEM_RD wait → mem_read=0 that cycle, no instr_done or reg_write; restart at FETCH.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the LEGv8 multicycle sequencer:
// state and instruction-class encodings, opcode constants, ALUOp values.
package control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_ADDR    = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_WB_R    = 4'd6,
    ST_WB_LD   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_ILLEGAL = 4'd10
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_CBZ   = 3'd3,
    CLS_B     = 3'd4,
    CLS_ILL   = 3'd5
  } instr_class_t;

  // Exact-match opcodes, instruction bits [31:21]
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // Range-decoded opcodes: CBZ 0x5A0-0x5A7, B 0x0A0-0x0BF
  localparam logic [7:0]  OP_CBZ_PFX = 8'hB4;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  // Same values as the ALUOp_* macros used by the decode stage
  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the datapath.
interface multicycle_control_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        reg2_loc;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        instr_done;
  logic        illegal;

  // Sequencer side: consumes IR/flags, drives the control set
  modport master (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, pc_src, reg2_loc, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_write, instr_done, illegal
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_src, reg2_loc, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_write, instr_done, illegal
  );
endinterface

// File: rtl/opcode_classify.sv
// Combinational opcode-to-instruction-class decoder.
module opcode_classify
  import control_pkg::*;
(
  input  logic [10:0]  i_opcode,
  output instr_class_t o_class
);

  // Exact matches first, then the CBZ and B ranges by prefix
  always_comb begin
    o_class = CLS_ILL;
    if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
        i_opcode == OP_AND || i_opcode == OP_ORR)
      o_class = CLS_RTYPE;
    else if (i_opcode == OP_LDUR)
      o_class = CLS_LOAD;
    else if (i_opcode == OP_STUR)
      o_class = CLS_STORE;
    else if (i_opcode[10:3] == OP_CBZ_PFX)
      o_class = CLS_CBZ;
    else if (i_opcode[10:5] == OP_B_PFX)
      o_class = CLS_B;
  end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables.
module multicycle_control
  import control_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  ctrl_state_t  r_state;
  instr_class_t r_class;
  instr_class_t w_class;

  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_reg2_loc;
  logic       w_alu_src;
  logic [1:0] w_alu_op;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_illegal;

  opcode_classify u_classify (
    .i_opcode (bus.opcode),
    .o_class  (w_class)
  );

  // State register; the class is captured on leaving DECODE so later IR changes are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_class <= CLS_RTYPE;
    end else begin
      case (r_state)
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: begin
          r_class <= w_class;
          case (w_class)
            CLS_RTYPE: r_state <= ST_EXEC_R;
            CLS_LOAD,
            CLS_STORE: r_state <= ST_ADDR;
            CLS_CBZ:   r_state <= ST_BRANCH;
            CLS_B:     r_state <= ST_JUMP;
            default:   r_state <= ST_ILLEGAL;
          endcase
        end
        ST_EXEC_R: r_state <= ST_WB_R;
        ST_ADDR:   r_state <= (r_class == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD: if (bus.mem_ready) r_state <= ST_WB_LD;
        ST_MEM_WR: if (bus.mem_ready) r_state <= ST_FETCH;
        ST_WB_R,
        ST_WB_LD,
        ST_BRANCH,
        ST_JUMP:   r_state <= ST_FETCH;
        ST_ILLEGAL: r_state <= ST_ILLEGAL;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  // Per-state control decode; reset gates every output low, which also drops in-flight strobes
  always_comb begin
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_reg2_loc   = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = ALUOP_LDST;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH:  w_ir_write = 1'b1;
        ST_DECODE: w_reg2_loc = (w_class == CLS_STORE) || (w_class == CLS_CBZ);
        ST_EXEC_R: w_alu_op = ALUOP_RTYPE;
        ST_ADDR: begin
          w_alu_src  = 1'b1;
          w_alu_op   = ALUOP_LDST;
          w_reg2_loc = (r_class == CLS_STORE);
        end
        ST_MEM_RD: begin
          w_alu_src  = 1'b1;
          w_mem_read = 1'b1;
        end
        ST_MEM_WR: begin
          w_alu_src    = 1'b1;
          w_reg2_loc   = 1'b1;
          w_mem_write  = 1'b1;
          w_pc_write   = bus.mem_ready;
          w_instr_done = bus.mem_ready;
        end
        ST_WB_R: begin
          w_alu_op     = ALUOP_RTYPE;
          w_reg_write  = 1'b1;
          w_pc_write   = 1'b1;
          w_instr_done = 1'b1;
        end
        ST_WB_LD: begin
          w_mem_to_reg = 1'b1;
          w_reg_write  = 1'b1;
          w_pc_write   = 1'b1;
          w_instr_done = 1'b1;
        end
        ST_BRANCH: begin
          w_reg2_loc   = 1'b1;
          w_alu_op     = ALUOP_CBZ;
          w_pc_write   = 1'b1;
          w_pc_src     = bus.zero;
          w_instr_done = 1'b1;
        end
        ST_JUMP: begin
          w_pc_write   = 1'b1;
          w_pc_src     = 1'b1;
          w_instr_done = 1'b1;
        end
        ST_ILLEGAL: w_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ir_write   = w_ir_write;
  assign bus.pc_write   = w_pc_write;
  assign bus.pc_src     = w_pc_src;
  assign bus.reg2_loc   = w_reg2_loc;
  assign bus.alu_src    = w_alu_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.reg_write  = w_reg_write;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal    = w_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control words.
module tb_multicycle_control;

  // Control word layout used for expectations
  localparam logic [12:0] IRW  = 13'h1000;  // ir_write
  localparam logic [12:0] PCW  = 13'h0800;  // pc_write
  localparam logic [12:0] PCS  = 13'h0400;  // pc_src
  localparam logic [12:0] R2L  = 13'h0200;  // reg2_loc
  localparam logic [12:0] ALS  = 13'h0100;  // alu_src
  localparam logic [12:0] AOPR = 13'h0080;  // alu_op = 10
  localparam logic [12:0] AOPC = 13'h0040;  // alu_op = 01
  localparam logic [12:0] MRD  = 13'h0020;  // mem_read
  localparam logic [12:0] MWR  = 13'h0010;  // mem_write
  localparam logic [12:0] M2R  = 13'h0008;  // mem_to_reg
  localparam logic [12:0] RW   = 13'h0004;  // reg_write
  localparam logic [12:0] DONE = 13'h0002;  // instr_done
  localparam logic [12:0] ILL  = 13'h0001;  // illegal

  typedef struct {
    logic        rn;
    logic [10:0] op;
    logic        z;
    logic        mr;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [12:0] sb[$];
  vec_t tbl[$];

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] got_word();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.reg2_loc, bus.alu_src,
            bus.alu_op, bus.mem_read, bus.mem_write, bus.mem_to_reg,
            bus.reg_write, bus.instr_done, bus.illegal};
  endfunction

  // Drive one cycle after the rising edge, check at the falling edge
  task automatic step(input logic rn, input logic [10:0] op, input logic z,
                      input logic mr, input logic [12:0] exp, input string nm);
    logic [12:0] e;
    logic [12:0] g;
    @(posedge clk);
    #1;
    rst_n         = rn;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    sb.push_back(exp);
    @(negedge clk);
    g = got_word();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", nm, g);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", nm, g, e);
      end
    end
    if (bus.mem_read && bus.mem_write) begin
      errors++;
      $display("FAIL %s: mem_read and mem_write both high", nm);
    end
  endtask

  task automatic add(input logic rn, input logic [10:0] op, input logic z,
                     input logic mr, input logic [12:0] exp);
    tbl.push_back('{rn: rn, op: op, z: z, mr: mr, exp: exp});
  endtask

  initial begin
    bus.opcode    = 11'h458;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset holds outputs low, then first cycle is FETCH
    add(0, 11'h458, 0, 0, 13'h0);
    add(0, 11'h458, 0, 1, 13'h0);
    // ADD: 4 cycles
    add(1, 11'h458, 0, 0, IRW);
    add(1, 11'h458, 0, 0, 13'h0);
    add(1, 11'h458, 0, 1, AOPR);
    add(1, 11'h458, 0, 1, AOPR | RW | PCW | DONE);
    // LDUR with 2 wait cycles: 7 cycles
    add(1, 11'h7C2, 0, 1, IRW);
    add(1, 11'h7C2, 0, 1, 13'h0);
    add(1, 11'h7C2, 0, 1, ALS);
    add(1, 11'h7C2, 0, 0, ALS | MRD);
    add(1, 11'h7C2, 0, 0, ALS | MRD);
    add(1, 11'h7C2, 0, 1, ALS | MRD);
    add(1, 11'h7C2, 0, 0, M2R | RW | PCW | DONE);
    // STUR with ready immediately
    add(1, 11'h7C0, 0, 1, IRW);
    add(1, 11'h7C0, 0, 1, R2L);
    add(1, 11'h7C0, 0, 0, ALS | R2L);
    add(1, 11'h7C0, 0, 1, ALS | R2L | MWR | PCW | DONE);
    // STUR with one wait cycle
    add(1, 11'h7C0, 0, 0, IRW);
    add(1, 11'h7C0, 0, 0, R2L);
    add(1, 11'h7C0, 0, 1, ALS | R2L);
    add(1, 11'h7C0, 0, 0, ALS | R2L | MWR);
    add(1, 11'h7C0, 0, 1, ALS | R2L | MWR | PCW | DONE);
    // CBZ taken, then not taken
    add(1, 11'h5A3, 1, 0, IRW);
    add(1, 11'h5A3, 1, 0, R2L);
    add(1, 11'h5A3, 1, 0, R2L | AOPC | PCW | PCS | DONE);
    add(1, 11'h5A3, 0, 0, IRW);
    add(1, 11'h5A3, 0, 0, R2L);
    add(1, 11'h5A3, 0, 1, R2L | AOPC | PCW | DONE);
    // CBZ range top
    add(1, 11'h5A7, 1, 0, IRW);
    add(1, 11'h5A7, 1, 0, R2L);
    add(1, 11'h5A7, 1, 0, R2L | AOPC | PCW | PCS | DONE);
    // B middle and both range ends
    add(1, 11'h0AF, 0, 0, IRW);
    add(1, 11'h0AF, 0, 0, 13'h0);
    add(1, 11'h0AF, 0, 0, PCW | PCS | DONE);
    add(1, 11'h0A0, 0, 0, IRW);
    add(1, 11'h0A0, 0, 0, 13'h0);
    add(1, 11'h0A0, 0, 0, PCW | PCS | DONE);
    add(1, 11'h0BF, 0, 0, IRW);
    add(1, 11'h0BF, 0, 0, 13'h0);
    add(1, 11'h0BF, 0, 0, PCW | PCS | DONE);
    // SUB, opcode changes after DECODE are ignored
    add(1, 11'h658, 0, 0, IRW);
    add(1, 11'h658, 0, 0, 13'h0);
    add(1, 11'h7C0, 0, 0, AOPR);
    add(1, 11'h765, 0, 0, AOPR | RW | PCW | DONE);
    // AND and ORR
    add(1, 11'h450, 0, 0, IRW);
    add(1, 11'h450, 0, 0, 13'h0);
    add(1, 11'h450, 0, 0, AOPR);
    add(1, 11'h450, 0, 0, AOPR | RW | PCW | DONE);
    add(1, 11'h550, 0, 0, IRW);
    add(1, 11'h550, 0, 0, 13'h0);
    add(1, 11'h550, 0, 0, AOPR);
    add(1, 11'h550, 0, 0, AOPR | RW | PCW | DONE);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rn, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].exp, $sformatf("vec%0d", i));

    // Reset while waiting in MEM_RD: strobe drops, no writeback, restart at FETCH
    step(1, 11'h7C2, 0, 0, IRW, "rdabort_fetch");
    step(1, 11'h7C2, 0, 0, 13'h0, "rdabort_decode");
    step(1, 11'h7C2, 0, 0, ALS, "rdabort_addr");
    step(1, 11'h7C2, 0, 0, ALS | MRD, "rdabort_wait");
    step(0, 11'h7C2, 0, 1, 13'h0, "rdabort_rst");
    step(1, 11'h458, 0, 1, IRW, "rdabort_refetch");
    step(1, 11'h458, 0, 0, 13'h0, "rdabort_decode2");
    step(1, 11'h458, 0, 0, AOPR, "rdabort_exec");
    step(1, 11'h458, 0, 0, AOPR | RW | PCW | DONE, "rdabort_wb");

    // Reset while waiting in MEM_WR
    step(1, 11'h7C0, 0, 0, IRW, "wrabort_fetch");
    step(1, 11'h7C0, 0, 0, R2L, "wrabort_decode");
    step(1, 11'h7C0, 0, 0, ALS | R2L, "wrabort_addr");
    step(1, 11'h7C0, 0, 0, ALS | R2L | MWR, "wrabort_wait");
    step(0, 11'h7C0, 0, 1, 13'h0, "wrabort_rst");
    step(1, 11'h0AF, 0, 0, IRW, "wrabort_refetch");
    step(1, 11'h0AF, 0, 0, 13'h0, "wrabort_decode2");
    step(1, 11'h0AF, 0, 0, PCW | PCS | DONE, "wrabort_jump");

    // Undefined opcode: sticky illegal, inputs ignored, cleared by reset
    step(1, 11'h765, 0, 0, IRW, "ill_fetch");
    step(1, 11'h765, 0, 0, 13'h0, "ill_decode");
    for (int i = 0; i < 12; i++)
      step(1, (i % 2) ? 11'h458 : 11'h7C2, i[0], ~i[0], ILL, $sformatf("ill_hold%0d", i));
    step(0, 11'h458, 0, 0, 13'h0, "ill_rst");
    step(1, 11'h458, 0, 0, IRW, "ill_refetch");
    step(1, 11'h458, 0, 0, 13'h0, "ill_decode2");
    step(1, 11'h458, 0, 0, AOPR, "ill_exec");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
